// File: rtl/pe_pkg.sv
// Shared constants and types for the per-PE weight-memory address path.
package pe_pkg;

  localparam int IDX_W      = 12;
  localparam int MEM_ADDR_W = 14;
  localparam int DATA_W     = 16;
  localparam int HASH_SHIFT = 5;

  typedef enum logic {
    MODE_DENSE = 1'b0,
    MODE_HASH  = 1'b1
  } addr_mode_e;

  // Bank-select width never collapses to zero, even with a single bank.
  function automatic int bank_w(input int nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

endpackage

// File: rtl/w_addr_hash.sv
// Combinational final address computation (dense or pseudo-hash) and split
// into bank select plus bank-local address.
module w_addr_hash
  import pe_pkg::*;
#(
  parameter int                ADDR_W  = MEM_ADDR_W,
  parameter int                NB      = 2,
  parameter logic [ADDR_W-1:0] SEED    = 'h5A5,
  localparam int               LOG2_NB = $clog2(NB),
  localparam int               BANK_W  = bank_w(NB)
) (
  input  addr_mode_e                  mode,
  input  logic [ADDR_W-1:0]           prod,
  input  logic [ADDR_W-1:0]           lin,
  input  logic [ADDR_W-1:0]           mask,
  input  logic [ADDR_W-1:0]           offset,
  output logic [BANK_W-1:0]           bank,
  output logic [ADDR_W-LOG2_NB-1:0]   bank_addr
);

  logic [ADDR_W-1:0] hashed;
  logic [ADDR_W-1:0] addr;

  always_comb begin
    hashed = (lin ^ (lin >> HASH_SHIFT) ^ SEED) & mask;
    addr   = offset + ((mode == MODE_HASH) ? hashed : prod);
  end

  // Low address bits interleave consecutive words across banks.
  if (LOG2_NB == 0) begin : g_single_bank
    assign bank      = '0;
    assign bank_addr = addr;
  end else begin : g_multi_bank
    assign bank      = addr[LOG2_NB-1:0];
    assign bank_addr = addr[ADDR_W-1:LOG2_NB];
  end

endmodule

// File: rtl/w_addr_gen.sv
// Two-stage weight-SRAM read address generator: S1 computes the index products,
// MEM tracks the token whose SRAM read data is on the bank Q outputs.
module w_addr_gen
  import pe_pkg::addr_mode_e, pe_pkg::MODE_DENSE, pe_pkg::MODE_HASH, pe_pkg::bank_w;
#(
  parameter int                    PE_IDX_W   = 6,
  parameter int                    ACT_ADDR_W = 6,
  parameter int                    IDX_W      = pe_pkg::IDX_W,
  parameter int                    MEM_ADDR_W = pe_pkg::MEM_ADDR_W,
  parameter int                    DATA_W     = pe_pkg::DATA_W,
  parameter int                    NUM_BANKS  = 2,
  parameter logic [MEM_ADDR_W-1:0] HASH_SEED  = 'h5A5,
  localparam int                   LOG2_NB    = $clog2(NUM_BANKS),
  localparam int                   BANK_W     = bank_w(NUM_BANKS),
  localparam int                   LADDR_W    = MEM_ADDR_W - LOG2_NB
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PE_IDX_W-1:0]   pe_idx,
  input  logic                  cfg_hash,
  input  logic [MEM_ADDR_W-1:0] cfg_bucket_mask,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IDX_W-1:0]      in_act_idx,
  input  logic [ACT_ADDR_W-1:0] out_act_addr,
  input  logic [IDX_W-1:0]      col_dim,
  input  logic [MEM_ADDR_W-1:0] w_mem_offset,
  input  logic [DATA_W-1:0]     in_act_value,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_act_value,
  output logic [ACT_ADDR_W-1:0] out_act_addr_mem,
  output logic [BANK_W-1:0]     out_bank,
  output logic [NUM_BANKS-1:0]  w_mem_cen,
  output logic                  w_mem_wen,
  output logic [LADDR_W-1:0]    w_mem_addr,
  output logic [15:0]           rd_cnt,
  output logic                  busy
);

  // S1 (calc) stage
  logic                  s1_valid_q,  s1_valid_d;
  logic [MEM_ADDR_W-1:0] s1_prod_q,   s1_prod_d;
  logic [MEM_ADDR_W-1:0] s1_lin_q,    s1_lin_d;
  addr_mode_e            s1_mode_q,   s1_mode_d;
  logic [MEM_ADDR_W-1:0] s1_mask_q,   s1_mask_d;
  logic [MEM_ADDR_W-1:0] s1_offset_q, s1_offset_d;
  logic [DATA_W-1:0]     s1_value_q,  s1_value_d;
  logic [ACT_ADDR_W-1:0] s1_oaddr_q,  s1_oaddr_d;

  // MEM stage
  logic                  mem_valid_q, mem_valid_d;
  logic [DATA_W-1:0]     mem_value_q, mem_value_d;
  logic [ACT_ADDR_W-1:0] mem_oaddr_q, mem_oaddr_d;
  logic [BANK_W-1:0]     mem_bank_q,  mem_bank_d;

  logic [LADDR_W-1:0]    addr_hold_q, addr_hold_d;
  logic [15:0]           rd_cnt_q,    rd_cnt_d;

  logic                  advance;
  logic                  accept;
  logic [BANK_W-1:0]     issue_bank;
  logic [LADDR_W-1:0]    issue_addr;

  w_addr_hash #(
    .ADDR_W (MEM_ADDR_W),
    .NB     (NUM_BANKS),
    .SEED   (HASH_SEED)
  ) u_hash (
    .mode      (s1_mode_q),
    .prod      (s1_prod_q),
    .lin       (s1_lin_q),
    .mask      (s1_mask_q),
    .offset    (s1_offset_q),
    .bank      (issue_bank),
    .bank_addr (issue_addr)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    advance  = s1_valid_q && (!mem_valid_q || out_ready);
    in_ready = !s1_valid_q || advance;
    accept   = in_valid && in_ready;

    s1_valid_d  = s1_valid_q;
    s1_prod_d   = s1_prod_q;
    s1_lin_d    = s1_lin_q;
    s1_mode_d   = s1_mode_q;
    s1_mask_d   = s1_mask_q;
    s1_offset_d = s1_offset_q;
    s1_value_d  = s1_value_q;
    s1_oaddr_d  = s1_oaddr_q;
    if (accept) begin
      s1_valid_d  = 1'b1;
      s1_prod_d   = MEM_ADDR_W'(out_act_addr) * MEM_ADDR_W'(col_dim)
                  + MEM_ADDR_W'(in_act_idx);
      s1_lin_d    = MEM_ADDR_W'({out_act_addr, pe_idx}) * MEM_ADDR_W'(col_dim)
                  + MEM_ADDR_W'(in_act_idx);
      s1_mode_d   = cfg_hash ? MODE_HASH : MODE_DENSE;
      s1_mask_d   = cfg_bucket_mask;
      s1_offset_d = w_mem_offset;
      s1_value_d  = in_act_value;
      s1_oaddr_d  = out_act_addr;
    end else if (advance) begin
      s1_valid_d  = 1'b0;
    end

    mem_valid_d = mem_valid_q;
    mem_value_d = mem_value_q;
    mem_oaddr_d = mem_oaddr_q;
    mem_bank_d  = mem_bank_q;
    if (advance) begin
      mem_valid_d = 1'b1;
      mem_value_d = s1_value_q;
      mem_oaddr_d = s1_oaddr_q;
      mem_bank_d  = issue_bank;
    end else if (out_ready) begin
      mem_valid_d = 1'b0;
    end

    // The bank-local address is shared and parks on the last issued read.
    addr_hold_d = advance ? issue_addr : addr_hold_q;
    rd_cnt_d    = (advance && rd_cnt_q != 16'hFFFF) ? rd_cnt_q + 16'd1 : rd_cnt_q;

    w_mem_cen = '1;
    if (advance) w_mem_cen[issue_bank] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_prod_q   <= '0;
      s1_lin_q    <= '0;
      s1_mode_q   <= MODE_DENSE;
      s1_mask_q   <= '0;
      s1_offset_q <= '0;
      s1_value_q  <= '0;
      s1_oaddr_q  <= '0;
      mem_valid_q <= 1'b0;
      mem_value_q <= '0;
      mem_oaddr_q <= '0;
      mem_bank_q  <= '0;
      addr_hold_q <= '0;
      rd_cnt_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_prod_q   <= s1_prod_d;
      s1_lin_q    <= s1_lin_d;
      s1_mode_q   <= s1_mode_d;
      s1_mask_q   <= s1_mask_d;
      s1_offset_q <= s1_offset_d;
      s1_value_q  <= s1_value_d;
      s1_oaddr_q  <= s1_oaddr_d;
      mem_valid_q <= mem_valid_d;
      mem_value_q <= mem_value_d;
      mem_oaddr_q <= mem_oaddr_d;
      mem_bank_q  <= mem_bank_d;
      addr_hold_q <= addr_hold_d;
      rd_cnt_q    <= rd_cnt_d;
    end
  end

  assign w_mem_addr       = addr_hold_d;
  assign w_mem_wen        = 1'b1;
  assign out_valid        = mem_valid_q;
  assign out_act_value    = mem_value_q;
  assign out_act_addr_mem = mem_oaddr_q;
  assign out_bank         = mem_bank_q;
  assign rd_cnt           = rd_cnt_q;
  assign busy             = s1_valid_q | mem_valid_q;

endmodule
